// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the CPU request/response bus. It serves fetch,
//   load and store requests from three regions: a preloadable boot ROM at
//   0x0000, a scratch RAM at 0x8000 with configurable wait states, and a
//   two-word MMIO window (0xFF00 debug register R/W, 0xFF01 cycle counter RO).
//   Any other address, a ROM write or a counter write answers with an error
//   and 0xDEAD, and changes nothing.
//
//   FSM:
//     state   | meaning
//     IDLE    | ready for a request; req_ready=1
//     WAIT    | RAM wait states counting down
//     RESP    | one-cycle response strobe; RAM/debug writes commit on this edge
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/we/addr/wdata, req_ready        request channel
//   resp_valid/rdata/err                      response channel (no backpressure)
//   rom_we/waddr/wdata                        ROM preload port, usable any time
//   dbg_out                                   debug register value
//   busy                                      transaction in flight
module mem_bus_responder #(
   parameter int unsigned ROM_WORDS = 2048,
   parameter int unsigned RAM_WORDS = 1024,
   parameter int unsigned RAM_WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   input  logic        rom_we,
   input  logic [10:0] rom_waddr,
   input  logic [15:0] rom_wdata,
   output logic [15:0] dbg_out,
   output logic        busy
);

   localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Response data source: a captured word, or the ROM/RAM read register.
   localparam logic [1:0] SEL_DATA = 2'd0;
   localparam logic [1:0] SEL_ROM  = 2'd1;
   localparam logic [1:0] SEL_RAM  = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wcnt;
   logic [15:0] cnt_q;
   logic [15:0] dbg_q;

   logic [15:0] rom [ROM_WORDS];
   logic [15:0] ram [RAM_WORDS];
   logic [15:0] rom_q;
   logic [15:0] ram_q;

   // Decode of the request currently presented
   logic        hit_rom, hit_ram, hit_dbg, hit_cnt;
   logic        acc_err;
   logic [1:0]  acc_sel;
   logic [15:0] acc_data;
   logic        accept, wait_path, enter_resp;

   // Transaction captured at accept, used by WAIT/RESP
   logic              p_ram_wr;
   logic              p_dbg_wr;
   logic [RAM_AW-1:0] p_idx;
   logic [15:0]       p_wdata;
   logic [1:0]        p_sel;
   logic [15:0]       p_data;
   logic              p_err;

   // Response registers, only loaded on the edge entering RESP so that
   // resp_* hold steady between strobes.
   logic [1:0]        o_sel;
   logic [15:0]       o_data;
   logic              o_err;

   logic [1:0]        nxt_sel;
   logic [15:0]       nxt_data;
   logic              nxt_err;
   logic [RAM_AW-1:0] nxt_idx;

   always_comb begin
      hit_rom = 32'(req_addr) < ROM_WORDS;
      hit_ram = req_addr[15] && (32'(req_addr[14:0]) < RAM_WORDS);
      hit_dbg = req_addr == 16'hFF00;
      hit_cnt = req_addr == 16'hFF01;
      acc_err = !(hit_rom || hit_ram || hit_dbg || hit_cnt) ||
                (req_we && (hit_rom || hit_cnt));

      acc_sel  = SEL_DATA;
      acc_data = 16'h0000;
      if (acc_err) begin
         acc_data = 16'hDEAD;
      end else if (!req_we) begin
         if (hit_rom)      acc_sel  = SEL_ROM;
         else if (hit_ram) acc_sel  = SEL_RAM;
         else if (hit_dbg) acc_data = dbg_q;
         else              acc_data = cnt_q;
      end
   end

   assign accept     = (state == ST_IDLE) && req_valid;
   assign wait_path  = hit_ram && (RAM_WAIT != 0);
   assign enter_resp = (accept && !wait_path) || ((state == ST_WAIT) && (wcnt == 4'd0));

   // Directly from IDLE the response comes from the live decode; after WAIT
   // it comes from the captured copy.
   always_comb begin
      if (state == ST_IDLE) begin
         nxt_sel  = acc_sel;
         nxt_data = acc_data;
         nxt_err  = acc_err;
         nxt_idx  = req_addr[RAM_AW-1:0];
      end else begin
         nxt_sel  = p_sel;
         nxt_data = p_data;
         nxt_err  = p_err;
         nxt_idx  = p_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wcnt     <= 4'd0;
         cnt_q    <= 16'h0000;
         dbg_q    <= 16'h0000;
         p_ram_wr <= 1'b0;
         p_dbg_wr <= 1'b0;
         p_idx    <= '0;
         p_wdata  <= 16'h0000;
         p_sel    <= SEL_DATA;
         p_data   <= 16'h0000;
         p_err    <= 1'b0;
         o_sel    <= SEL_DATA;
         o_data   <= 16'h0000;
         o_err    <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  p_ram_wr <= req_we && hit_ram;
                  p_dbg_wr <= req_we && hit_dbg;
                  p_idx    <= req_addr[RAM_AW-1:0];
                  p_wdata  <= req_wdata;
                  p_sel    <= acc_sel;
                  p_data   <= acc_data;
                  p_err    <= acc_err;
                  if (wait_path) begin
                     state <= ST_WAIT;
                     wcnt  <= 4'(RAM_WAIT - 1);
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (wcnt == 4'd0) state <= ST_RESP;
               else              wcnt  <= wcnt - 4'd1;
            end
            ST_RESP: begin
               state <= ST_IDLE;
               if (p_dbg_wr) dbg_q <= p_wdata;
            end
            default: state <= ST_IDLE;
         endcase
         if (enter_resp) begin
            o_sel  <= nxt_sel;
            o_data <= nxt_data;
            o_err  <= nxt_err;
         end
      end
   end

   // Preload and bus read on the same edge: the read sees the old word.
   always_ff @(posedge clk) begin
      if (rom_we && (32'(rom_waddr) < ROM_WORDS))
         rom[rom_waddr[ROM_AW-1:0]] <= rom_wdata;
      if (accept && hit_rom && !req_we)
         rom_q <= rom[req_addr[ROM_AW-1:0]];
   end

   // RAM write commits on the RESP edge unless reset is asserted on that edge.
   always_ff @(posedge clk) begin
      if ((state == ST_RESP) && p_ram_wr && !rst)
         ram[p_idx] <= p_wdata;
      if (enter_resp && (nxt_sel == SEL_RAM))
         ram_q <= ram[nxt_idx];
   end

   always_comb begin
      case (o_sel)
         SEL_ROM: resp_rdata = rom_q;
         SEL_RAM: resp_rdata = ram_q;
         default: resp_rdata = o_data;
      endcase
   end

   assign resp_err   = o_err;
   assign resp_valid = (state == ST_RESP);
   assign req_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign dbg_out    = dbg_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic        rom_we;
   logic [10:0] rom_waddr;
   logic [15:0] rom_wdata;
   logic [15:0] dbg_out;
   logic        busy;

   mem_bus_responder #(.ROM_WORDS(2048), .RAM_WORDS(1024), .RAM_WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
      .dbg_out(dbg_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic [15:0] m_cnt = 16'h0000;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) m_cnt <= 16'h0000;
      else     m_cnt <= m_cnt + 16'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".rdata"}, 32'(resp_rdata), 32'(e.rdata));
            chk({e.name, ".err"},   32'(resp_err),   32'(e.err));
            chk({e.name, ".cycle"}, 32'(cyc),        32'(e.due));
            chk({e.name, ".ready"}, 32'(req_ready),  32'd0);
         end
      end
   end

   // Present one request at a negedge; it is accepted on the following posedge.
   task automatic issue(input string name, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_err, input int lat);
      int k;
      exp_t e;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) chk({name, ".ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = cyc + 1 + lat;
      e.name  = name;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic rom_load(input logic [10:0] a, input logic [15:0] d);
      @(negedge clk);
      rom_we    = 1'b1;
      rom_waddr = a;
      rom_wdata = d;
      @(negedge clk);
      rom_we    = 1'b0;
   endtask

   initial begin : main
      logic [15:0] c0;
      exp_t e;
      int k;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
      rom_we = 1'b0; rom_waddr = 11'h0; rom_wdata = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst.req_ready",  32'(req_ready),  32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst.resp_err",   32'(resp_err),   32'd0);
      chk("rst.dbg_out",    32'(dbg_out),    32'd0);
      chk("rst.busy",       32'(busy),       32'd0);
      rst = 1'b0;

      rom_load(11'd0, 16'h07E1);
      rom_load(11'd1, 16'h05D1);
      rom_load(11'd2, 16'h0751);
      rom_load(11'd3, 16'h0BC1);

      issue("rom_rd2", 1'b0, 16'h0002, 16'h0, 16'h0751, 1'b0, 0);

      issue("ram_wr5", 1'b1, 16'h8005, 16'hBEEF, 16'h0000, 1'b0, 2);
      chk("wait.req_ready", 32'(req_ready), 32'd0);
      chk("wait.busy",      32'(busy),      32'd1);
      issue("ram_rd5", 1'b0, 16'h8005, 16'h0, 16'hBEEF, 1'b0, 2);
      issue("ram_wr_last", 1'b1, 16'h83FF, 16'hA5A5, 16'h0000, 1'b0, 2);
      issue("ram_rd_last", 1'b0, 16'h83FF, 16'h0, 16'hA5A5, 1'b0, 2);

      issue("rom_wr_err", 1'b1, 16'h0001, 16'h1111, 16'hDEAD, 1'b1, 0);
      issue("rom_rd1",    1'b0, 16'h0001, 16'h0, 16'h05D1, 1'b0, 0);
      issue("unmap_4000", 1'b0, 16'h4000, 16'h0, 16'hDEAD, 1'b1, 0);
      issue("unmap_0800", 1'b0, 16'h0800, 16'h0, 16'hDEAD, 1'b1, 0);
      issue("unmap_8400", 1'b0, 16'h8400, 16'h0, 16'hDEAD, 1'b1, 0);
      issue("rom_rd2b",   1'b0, 16'h0002, 16'h0, 16'h0751, 1'b0, 0);

      issue("dbg_wr", 1'b1, 16'hFF00, 16'h1234, 16'h0000, 1'b0, 0);
      chk("dbg_out.during_resp", 32'(dbg_out), 32'h0000);
      @(negedge clk);
      chk("dbg_out.after_resp", 32'(dbg_out), 32'h1234);
      issue("dbg_rd",     1'b0, 16'hFF00, 16'h0, 16'h1234, 1'b0, 0);
      issue("cnt_wr_err", 1'b1, 16'hFF01, 16'h7777, 16'hDEAD, 1'b1, 0);

      // Preload and bus read of the same word in the same cycle.
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003;
      rom_we = 1'b1; rom_waddr = 11'd3; rom_wdata = 16'hAAAA;
      e.rdata = 16'h0BC1; e.err = 1'b0; e.due = cyc + 1; e.name = "rom_rd_wr_same";
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; rom_we = 1'b0;
      issue("rom_rd3_new", 1'b0, 16'h0003, 16'h0, 16'hAAAA, 1'b0, 0);

      // Counter: two reads with accepts 10 cycles apart.
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      c0 = m_cnt + 16'd1;
      issue("cnt_rd_a", 1'b0, 16'hFF01, 16'h0, c0, 1'b0, 0);
      repeat (8) @(negedge clk);
      issue("cnt_rd_b", 1'b0, 16'hFF01, 16'h0, c0 + 16'd10, 1'b0, 0);

      // Counter wrap: accept with counter at 0xFFFF, then again at 0x0001.
      k = 0;
      while (m_cnt != 16'hFFFE && k < 70000) begin
         @(negedge clk);
         k++;
      end
      chk("wrap.reach", 32'(m_cnt), 32'h0000FFFE);
      issue("cnt_rd_ffff", 1'b0, 16'hFF01, 16'h0, 16'hFFFF, 1'b0, 0);
      issue("cnt_rd_wrap", 1'b0, 16'hFF01, 16'h0, 16'h0001, 1'b0, 0);

      // Reset during the WAIT of a RAM write: nothing must come back.
      issue("ram_wr10_zero", 1'b1, 16'h8010, 16'h0000, 16'h0000, 1'b0, 2);
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h8010; req_wdata = 16'h5555;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      chk("rstmid.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid.req_ready", 32'(req_ready), 32'd1);
      chk("rstmid.busy",      32'(busy),      32'd0);
      repeat (4) @(negedge clk);
      issue("ram_rd10", 1'b0, 16'h8010, 16'h0, 16'h0000, 1'b0, 2);

      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain.outstanding", 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's request/response data bus.
- Answers fetch, load and store requests from the CPU core out of three regions: boot ROM (preloadable), scratch RAM with configurable wait states, and a small MMIO window (debug register, cycle counter).
- Replaces direct combinational indexing of the boot ROM by the core; the core becomes a pure bus initiator.

Parameters:
- ROM_WORDS, 2048: boot ROM depth in 16-bit words; base address 0x0000.
- RAM_WORDS, 1024: scratch RAM depth in 16-bit words; base address 0x8000.
- RAM_WAIT, 2: extra wait cycles for RAM accesses, range 0..15.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address
- req_wdata  in  16  write data
- req_ready  out  1  responder can accept a request
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  16  read data, valid with resp_valid
- resp_err  out  1  access error, valid with resp_valid
- rom_we  in  1  ROM preload write strobe
- rom_waddr  in  11  ROM preload address
- rom_wdata  in  16  ROM preload data
- dbg_out  out  16  current debug register value
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dbg_out=0, busy=0, cycle counter=0, state=IDLE. ROM and RAM contents are not reset.
- Address map:
  - ROM: 0x0000..ROM_WORDS-1.
  - RAM: 0x8000..0x8000+RAM_WORDS-1.
  - 0xFF00: debug register, R/W.
  - 0xFF01: cycle counter, read-only.
  - Any other address: error.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata and decode the region. RAM with RAM_WAIT>0 goes to WAIT with the wait counter loaded to RAM_WAIT-1. All other cases go to RESP.
  - WAIT: req_ready=0. Decrement the counter; at 0 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
- Latency (accept in cycle t):
  - Non-RAM, or RAM with RAM_WAIT=0: resp_valid in cycle t+1.
  - RAM: resp_valid in cycle t+1+RAM_WAIT.
  - req_ready reasserts the cycle after resp_valid. Maximum throughput is one request per 2 cycles.
- No response backpressure; the initiator must sample resp_* when resp_valid=1.
- resp_rdata and resp_err hold their last values between strobes.
- Reads:
  - ROM and RAM are read-first, synchronous.
  - 0xFF00 returns the debug register.
  - 0xFF01 returns the counter value captured in the accept cycle.
  - Writes return resp_rdata=0.
- Writes:
  - RAM and the debug register update on the RESP edge. dbg_out follows the cycle after.
- Errors (resp_err=1, resp_rdata=0xDEAD, no state change):
  - write to ROM
  - write to 0xFF01
  - unmapped address
- Cycle counter: 16-bit, increments every non-reset cycle, wraps 0xFFFF->0x0000.
- ROM preload:
  - rom_we writes ROM[rom_waddr] in any state.
  - A simultaneous bus read of the same address returns the old word.
  - rom_waddr >= ROM_WORDS is ignored.
- Reset mid-transaction: return to IDLE and drop the pending response. A pending RAM or debug write is discarded, with RAM unmodified.
- req_* is don't-care while req_ready=0.

Test Plan:
- Preload ROM[0..3]=0x07E1,0x05D1,0x0751,0x0BC1 via rom_we. Read addr 0x0002, accept at t -> resp_valid at t+1, rdata=0x0751, err=0.
- RAM_WAIT=2: write 0x8005=0xBEEF, then read 0x8005 -> each resp_valid exactly 3 cycles after accept, read rdata=0xBEEF. req_ready is low from accept until resp_valid inclusive.
- Write 0x0001 (ROM) -> resp_err=1, rdata=0xDEAD; a subsequent read of 0x0001 returns 0x05D1. Read 0x4000 -> err=1, rdata=0xDEAD.
- Write 0xFF00=0x1234 -> dbg_out=0x1234 the cycle after resp_valid. Read 0xFF00 -> 0x1234. Write 0xFF01 -> err=1.
- Counter: read 0xFF01 twice with accepts 10 cycles apart -> values differ by 10. Run across 0xFFFF -> wraps to 0x0000.
- Assert rst during WAIT of a RAM write of 0x5555 to 0x8010 (prior value 0x0000) -> no resp_valid, req_ready=1 after reset, a read of 0x8010 returns 0x0000.
